// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the dispatch stage.
package dispatcher_pkg;
  localparam int ROB_ID_W = 4;
  localparam int OPENUM_W = 6;

  typedef logic [31:0]          DATA_TYPE;
  typedef logic [31:0]          ADDR_TYPE;
  typedef logic [ROB_ID_W-1:0]  ROB_ID_TYPE;
  typedef logic [OPENUM_W-1:0]  OPENUM_TYPE;
  typedef logic [4:0]           REG_IDX_TYPE;

  localparam ROB_ID_TYPE ZERO_ROB   = '0;
  localparam DATA_TYPE   ZERO_WORD  = '0;
  localparam OPENUM_TYPE OPENUM_NOP = '0;
  localparam logic       TRUE       = 1'b1;
  localparam logic       FALSE      = 1'b0;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} slot_state_t;

  typedef struct packed {
    OPENUM_TYPE  openum;
    REG_IDX_TYPE rd;
    REG_IDX_TYPE rs1;
    REG_IDX_TYPE rs2;
    DATA_TYPE    imm;
    ADDR_TYPE    pc;
    logic        is_ls;
  } inst_t;
endpackage

// File: rtl/dispatcher_operand_resolver.sv
// Per-operand source resolution: x0, regfile value, arith CDB, LS CDB, ROB, else wait on tag.
// Purely combinational, zero latency; no flow control.
module operand_resolver
  import dispatcher_pkg::*;
(
  input  logic [4:0]          rs,
  input  logic [ROB_ID_W-1:0] q_reg,
  input  logic [31:0]         v_reg,
  input  logic                arith_vld,
  input  logic [ROB_ID_W-1:0] arith_id,
  input  logic [31:0]         arith_dat,
  input  logic                ls_vld,
  input  logic [ROB_ID_W-1:0] ls_id,
  input  logic [31:0]         ls_dat,
  input  logic                rob_ready,
  input  logic [31:0]         rob_value,
  output logic [ROB_ID_W-1:0] q,
  output logic [31:0]         v
);
  always_comb begin
    q = ZERO_ROB;
    v = ZERO_WORD;
    if (rs != 5'd0) begin
      if (q_reg == ZERO_ROB)
        v = v_reg;
      else if (arith_vld && (arith_id == q_reg))
        v = arith_dat;
      else if (ls_vld && (ls_id == q_reg))
        v = ls_dat;
      else if (rob_ready)
        v = rob_value;
      else
        q = q_reg;
    end
  end
endmodule

// File: rtl/dispatcher.sv
// One-slot dispatch stage: resolves operands, allocates ROB, renames rd, issues to RS or LSB.
// Capture at edge N, registered issue pulse at edge N+1 at the earliest.
// Holds the slot while ROB/target is full or was enabled last cycle; at most one issue per two cycles.
module dispatcher
  import dispatcher_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                inst_valid_from_iq,
  input  logic [OPENUM_W-1:0] openum_from_iq,
  input  logic [4:0]          rd_from_iq,
  input  logic [4:0]          rs1_from_iq,
  input  logic [4:0]          rs2_from_iq,
  input  logic [31:0]         imm_from_iq,
  input  logic [31:0]         pc_from_iq,
  input  logic                is_ls_from_iq,
  output logic                inst_ready_to_iq,
  output logic [4:0]          rs1_to_reg,
  output logic [4:0]          rs2_to_reg,
  input  logic [ROB_ID_W-1:0] Q1_from_reg,
  input  logic [ROB_ID_W-1:0] Q2_from_reg,
  input  logic [31:0]         V1_from_reg,
  input  logic [31:0]         V2_from_reg,
  output logic                rename_enable_to_reg,
  output logic [4:0]          rename_rd_to_reg,
  output logic [ROB_ID_W-1:0] rename_rob_id_to_reg,
  input  logic                rob_full,
  input  logic [ROB_ID_W-1:0] rob_free_id,
  output logic [ROB_ID_W-1:0] Q1_to_rob,
  output logic [ROB_ID_W-1:0] Q2_to_rob,
  input  logic                rob_ready1,
  input  logic [31:0]         rob_value1,
  input  logic                rob_ready2,
  input  logic [31:0]         rob_value2,
  output logic                rob_enable,
  output logic [OPENUM_W-1:0] openum_to_rob,
  output logic [4:0]          rd_to_rob,
  output logic [31:0]         pc_to_rob,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                rs_enable,
  output logic                lsb_enable,
  output logic [OPENUM_W-1:0] openum_out,
  output logic [31:0]         V1_out,
  output logic [31:0]         V2_out,
  output logic [ROB_ID_W-1:0] Q1_out,
  output logic [ROB_ID_W-1:0] Q2_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         imm_out,
  output logic [ROB_ID_W-1:0] rob_id_out,
  input  logic                valid_arith_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_arith_cdb,
  input  logic [31:0]         result_arith_cdb,
  input  logic                valid_ls_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_ls_cdb,
  input  logic [31:0]         result_ls_cdb,
  input  logic                misbranch_flag
);
  slot_state_t state, state_nxt;
  inst_t       slot, iq_inst;
  logic        slot_valid, target_ok, issue_fire, capture;
  ROB_ID_TYPE  q1_res, q2_res;
  DATA_TYPE    v1_res, v2_res;

  assign iq_inst = '{openum: openum_from_iq, rd: rd_from_iq, rs1: rs1_from_iq,
                     rs2: rs2_from_iq, imm: imm_from_iq, pc: pc_from_iq, is_ls: is_ls_from_iq};

  // Downstream full flags lag our own enable by a cycle, so a pending pulse also blocks.
  assign slot_valid       = (state == HELD);
  assign target_ok        = slot.is_ls ? (!lsb_full && !lsb_enable) : (!rs_full && !rs_enable);
  assign issue_fire       = rdy && !misbranch_flag && slot_valid && !rob_full && !rob_enable && target_ok;
  assign inst_ready_to_iq = rdy && !misbranch_flag && (!slot_valid || issue_fire);
  assign capture          = inst_ready_to_iq && inst_valid_from_iq;

  assign rs1_to_reg = slot.rs1;
  assign rs2_to_reg = slot.rs2;
  assign Q1_to_rob  = Q1_from_reg;
  assign Q2_to_rob  = Q2_from_reg;

  operand_resolver u_res1 (
    .rs(slot.rs1), .q_reg(Q1_from_reg), .v_reg(V1_from_reg),
    .arith_vld(valid_arith_cdb), .arith_id(rob_id_arith_cdb), .arith_dat(result_arith_cdb),
    .ls_vld(valid_ls_cdb), .ls_id(rob_id_ls_cdb), .ls_dat(result_ls_cdb),
    .rob_ready(rob_ready1), .rob_value(rob_value1), .q(q1_res), .v(v1_res)
  );

  operand_resolver u_res2 (
    .rs(slot.rs2), .q_reg(Q2_from_reg), .v_reg(V2_from_reg),
    .arith_vld(valid_arith_cdb), .arith_id(rob_id_arith_cdb), .arith_dat(result_arith_cdb),
    .ls_vld(valid_ls_cdb), .ls_id(rob_id_ls_cdb), .ls_dat(result_ls_cdb),
    .rob_ready(rob_ready2), .rob_value(rob_value2), .q(q2_res), .v(v2_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Capture wins over issue: a same-cycle issue and reload leaves the slot held.
  always_comb begin
    state_nxt = state;
    if (misbranch_flag)  state_nxt = EMPTY;
    else if (capture)    state_nxt = HELD;
    else if (issue_fire) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         slot <= '0;
    else if (capture) slot <= iq_inst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_enable           <= FALSE;
      rs_enable            <= FALSE;
      lsb_enable           <= FALSE;
      rename_enable_to_reg <= FALSE;
      rename_rd_to_reg     <= '0;
      rename_rob_id_to_reg <= ZERO_ROB;
      openum_to_rob        <= OPENUM_NOP;
      rd_to_rob            <= '0;
      pc_to_rob            <= ZERO_WORD;
      openum_out           <= OPENUM_NOP;
      V1_out               <= ZERO_WORD;
      V2_out               <= ZERO_WORD;
      Q1_out               <= ZERO_ROB;
      Q2_out               <= ZERO_ROB;
      pc_out               <= ZERO_WORD;
      imm_out              <= ZERO_WORD;
      rob_id_out           <= ZERO_ROB;
    end else if (misbranch_flag) begin
      rob_enable           <= FALSE;
      rs_enable            <= FALSE;
      lsb_enable           <= FALSE;
      rename_enable_to_reg <= FALSE;
    end else if (rdy) begin
      rob_enable           <= issue_fire;
      rs_enable            <= issue_fire && !slot.is_ls;
      lsb_enable           <= issue_fire && slot.is_ls;
      rename_enable_to_reg <= issue_fire && (slot.rd != 5'd0);
      if (issue_fire) begin
        rename_rd_to_reg     <= slot.rd;
        rename_rob_id_to_reg <= rob_free_id;
        openum_to_rob        <= slot.openum;
        rd_to_rob            <= slot.rd;
        pc_to_rob            <= slot.pc;
        openum_out           <= slot.openum;
        V1_out               <= v1_res;
        V2_out               <= v2_res;
        Q1_out               <= q1_res;
        Q2_out               <= q2_res;
        pc_out               <= slot.pc;
        imm_out              <= slot.imm;
        rob_id_out           <= rob_free_id;
      end
    end
  end
endmodule

// File: tb/tb_dispatcher.sv
// Directed and randomized checks of the dispatcher against a transaction-level reference.
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, inst_valid_from_iq, is_ls_from_iq;
  logic [5:0]  openum_from_iq;
  logic [4:0]  rd_from_iq, rs1_from_iq, rs2_from_iq;
  logic [31:0] imm_from_iq, pc_from_iq;
  logic        inst_ready_to_iq;
  logic [4:0]  rs1_to_reg, rs2_to_reg;
  logic [3:0]  Q1_from_reg, Q2_from_reg;
  logic [31:0] V1_from_reg, V2_from_reg;
  logic        rename_enable_to_reg;
  logic [4:0]  rename_rd_to_reg;
  logic [3:0]  rename_rob_id_to_reg;
  logic        rob_full;
  logic [3:0]  rob_free_id, Q1_to_rob, Q2_to_rob;
  logic        rob_ready1, rob_ready2;
  logic [31:0] rob_value1, rob_value2;
  logic        rob_enable;
  logic [5:0]  openum_to_rob;
  logic [4:0]  rd_to_rob;
  logic [31:0] pc_to_rob;
  logic        rs_full, lsb_full, rs_enable, lsb_enable;
  logic [5:0]  openum_out;
  logic [31:0] V1_out, V2_out, pc_out, imm_out;
  logic [3:0]  Q1_out, Q2_out, rob_id_out;
  logic        valid_arith_cdb, valid_ls_cdb, misbranch_flag;
  logic [3:0]  rob_id_arith_cdb, rob_id_ls_cdb;
  logic [31:0] result_arith_cdb, result_ls_cdb;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_valid_from_iq(inst_valid_from_iq), .openum_from_iq(openum_from_iq),
    .rd_from_iq(rd_from_iq), .rs1_from_iq(rs1_from_iq), .rs2_from_iq(rs2_from_iq),
    .imm_from_iq(imm_from_iq), .pc_from_iq(pc_from_iq), .is_ls_from_iq(is_ls_from_iq),
    .inst_ready_to_iq(inst_ready_to_iq), .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .rename_enable_to_reg(rename_enable_to_reg), .rename_rd_to_reg(rename_rd_to_reg),
    .rename_rob_id_to_reg(rename_rob_id_to_reg),
    .rob_full(rob_full), .rob_free_id(rob_free_id),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .rob_ready1(rob_ready1), .rob_value1(rob_value1),
    .rob_ready2(rob_ready2), .rob_value2(rob_value2),
    .rob_enable(rob_enable), .openum_to_rob(openum_to_rob),
    .rd_to_rob(rd_to_rob), .pc_to_rob(pc_to_rob),
    .rs_full(rs_full), .lsb_full(lsb_full), .rs_enable(rs_enable), .lsb_enable(lsb_enable),
    .openum_out(openum_out), .V1_out(V1_out), .V2_out(V2_out),
    .Q1_out(Q1_out), .Q2_out(Q2_out), .pc_out(pc_out), .imm_out(imm_out),
    .rob_id_out(rob_id_out),
    .valid_arith_cdb(valid_arith_cdb), .rob_id_arith_cdb(rob_id_arith_cdb),
    .result_arith_cdb(result_arith_cdb),
    .valid_ls_cdb(valid_ls_cdb), .rob_id_ls_cdb(rob_id_ls_cdb), .result_ls_cdb(result_ls_cdb),
    .misbranch_flag(misbranch_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        is_ls;
  } tinst_t;

  typedef struct {
    logic [3:0]  q1, q2;
    logic [31:0] v1, v2;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] ares;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] lres;
    logic        r1, r2;
    logic [31:0] rv1, rv2;
    logic [3:0]  fid;
  } env_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: returns {tag, value} for one operand.
  function automatic logic [35:0] ref_op(input logic [4:0] rs, input logic [3:0] q,
                                         input logic [31:0] v, input logic rr,
                                         input logic [31:0] rv, input env_t e);
    if (rs == 5'd0)             return {4'd0, 32'd0};
    if (q == 4'd0)              return {4'd0, v};
    if (e.av && (e.aid == q))   return {4'd0, e.ares};
    if (e.lv && (e.lid == q))   return {4'd0, e.lres};
    if (rr)                     return {4'd0, rv};
    return {q, 32'd0};
  endfunction

  task automatic drive_inst(input tinst_t t);
    openum_from_iq = t.op;  rd_from_iq  = t.rd;  rs1_from_iq = t.rs1; rs2_from_iq = t.rs2;
    imm_from_iq    = t.imm; pc_from_iq  = t.pc;  is_ls_from_iq = t.is_ls;
  endtask

  task automatic apply_env(input env_t e);
    Q1_from_reg = e.q1; Q2_from_reg = e.q2; V1_from_reg = e.v1; V2_from_reg = e.v2;
    valid_arith_cdb = e.av; rob_id_arith_cdb = e.aid; result_arith_cdb = e.ares;
    valid_ls_cdb = e.lv;    rob_id_ls_cdb = e.lid;    result_ls_cdb = e.lres;
    rob_ready1 = e.r1; rob_value1 = e.rv1; rob_ready2 = e.r2; rob_value2 = e.rv2;
    rob_free_id = e.fid;
  endtask

  function automatic env_t idle_env();
    env_t e;
    e = '{q1: 0, q2: 0, v1: 0, v2: 0, av: 0, aid: 0, ares: 0, lv: 0, lid: 0, lres: 0,
          r1: 0, r2: 0, rv1: 0, rv2: 0, fid: 4'd1};
    return e;
  endfunction

  function automatic tinst_t mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] pc, input logic is_ls);
    tinst_t t;
    t = '{op: op, rd: rd, rs1: rs1, rs2: rs2, imm: pc ^ 32'h00ff_0f0f, pc: pc, is_ls: is_ls};
    return t;
  endfunction

  // Capture one instruction into an empty slot, issue it under env e, check the pulse.
  task automatic run_one(input string tag, input tinst_t ins, input env_t e);
    logic [35:0] o1, o2;
    drive_inst(ins);
    inst_valid_from_iq = 1'b1;
    #1 chk({tag, "_ready"}, inst_ready_to_iq, 1);
    @(negedge clk);
    inst_valid_from_iq = 1'b0;
    apply_env(e);
    #1;
    chk({tag, "_rs1_idx"}, rs1_to_reg, ins.rs1);
    chk({tag, "_rs2_idx"}, rs2_to_reg, ins.rs2);
    chk({tag, "_q1_rob"}, Q1_to_rob, e.q1);
    chk({tag, "_no_early_en"}, rs_enable | lsb_enable, 0);
    @(negedge clk);
    o1 = ref_op(ins.rs1, e.q1, e.v1, e.r1, e.rv1, e);
    o2 = ref_op(ins.rs2, e.q2, e.v2, e.r2, e.rv2, e);
    chk({tag, "_rs_en"}, rs_enable, !ins.is_ls);
    chk({tag, "_lsb_en"}, lsb_enable, ins.is_ls);
    chk({tag, "_rob_en"}, rob_enable, 1);
    chk({tag, "_v1"}, V1_out, o1[31:0]);
    chk({tag, "_q1"}, Q1_out, o1[35:32]);
    chk({tag, "_v2"}, V2_out, o2[31:0]);
    chk({tag, "_q2"}, Q2_out, o2[35:32]);
    chk({tag, "_rob_id"}, rob_id_out, e.fid);
    chk({tag, "_rename_en"}, rename_enable_to_reg, ins.rd != 5'd0);
    if (ins.rd != 5'd0) begin
      chk({tag, "_rename_rd"}, rename_rd_to_reg, ins.rd);
      chk({tag, "_rename_tag"}, rename_rob_id_to_reg, e.fid);
    end
    chk({tag, "_op"}, openum_out, ins.op);
    chk({tag, "_pc"}, pc_out, ins.pc);
    chk({tag, "_imm"}, imm_out, ins.imm);
    chk({tag, "_rob_op"}, openum_to_rob, ins.op);
    chk({tag, "_rob_rd"}, rd_to_rob, ins.rd);
    chk({tag, "_rob_pc"}, pc_to_rob, ins.pc);
    apply_env(idle_env());
    @(negedge clk);
    chk({tag, "_pulse_end"}, {28'd0, rs_enable, lsb_enable, rob_enable, rename_enable_to_reg}, 0);
  endtask

  env_t        e;
  tinst_t      t, cur, exp_i;
  tinst_t      acc_q[$];
  int          ncap;
  logic [35:0] st_o1, st_o2;
  logic [3:0]  st_fid;
  logic        st_blocked, prev_en, cur_en, expect_issue, drain;

  initial begin
    rst = 1'b0; rdy = 1'b1; misbranch_flag = 1'b0; inst_valid_from_iq = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    drive_inst(mk(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0));
    apply_env(idle_env());

    // Reset state
    #12;
    chk("rst_rs_en", rs_enable, 0);
    chk("rst_lsb_en", lsb_enable, 0);
    chk("rst_rob_en", rob_enable, 0);
    chk("rst_rename_en", rename_enable_to_reg, 0);
    chk("rst_op_out", openum_out, OPENUM_NOP);
    chk("rst_op_rob", openum_to_rob, OPENUM_NOP);
    chk("rst_v1", V1_out, 0);
    chk("rst_rob_id", rob_id_out, 0);
    chk("rst_pc_rob", pc_to_rob, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ADDI x1, x2: register value ready
    e = idle_env(); e.v1 = 32'd5; e.fid = 4'd3;
    run_one("addi", mk(6'd10, 5'd1, 5'd2, 5'd0, 32'h100, 1'b0), e);

    // Operand forwarded from arithmetic CDB in the issue cycle
    e = idle_env(); e.q1 = 4'd7; e.v1 = 32'hdead; e.av = 1; e.aid = 4'd7; e.ares = 32'h1234;
    e.q2 = 4'd6; e.r2 = 1; e.rv2 = 32'h99; e.fid = 4'd4;
    run_one("arith_cdb", mk(6'd11, 5'd5, 5'd3, 5'd4, 32'h104, 1'b0), e);

    // Operand from ROB answer, no CDB
    e = idle_env(); e.q1 = 4'd7; e.r1 = 1; e.rv1 = 32'h55; e.fid = 4'd5;
    run_one("rob_val", mk(6'd11, 5'd6, 5'd3, 5'd0, 32'h108, 1'b0), e);

    // LS CDB beats ROB; operand 2 stays unresolved
    e = idle_env(); e.q1 = 4'd2; e.lv = 1; e.lid = 4'd2; e.lres = 32'habcd; e.r1 = 1;
    e.rv1 = 32'h77; e.q2 = 4'd9; e.av = 1; e.aid = 4'd8; e.ares = 32'h1; e.fid = 4'd6;
    run_one("ls_cdb", mk(6'd12, 5'd7, 5'd8, 5'd9, 32'h10c, 1'b0), e);

    // rd=0, rs1=0 with a stale regfile tag
    e = idle_env(); e.q1 = 4'd5; e.v1 = 32'h33; e.fid = 4'd7;
    run_one("x0", mk(6'd10, 5'd0, 5'd0, 5'd2, 32'h110, 1'b0), e);

    // Back-to-back instructions: issue every other cycle
    ncap = 0;
    t = mk(6'd10, 5'd3, 5'd1, 5'd2, 32'h200, 1'b0);
    for (int i = 0; i < 8; i++) begin
      t.pc = 32'h200 + 4 * ncap;
      drive_inst(t);
      inst_valid_from_iq = 1'b1;
      #1;
      chk("b2b_ready", inst_ready_to_iq, (i == 0) || (i % 2 == 1));
      chk("b2b_rs_en", rs_enable, (i >= 2) && (i % 2 == 0));
      if ((i >= 2) && (i % 2 == 0)) chk("b2b_pc", pc_out, 32'h200 + 4 * (i / 2 - 1));
      if ((i == 0) || (i % 2 == 1)) ncap++;
      @(negedge clk);
    end
    inst_valid_from_iq = 1'b0;
    repeat (4) @(negedge clk);

    // LW blocked by a full LSB for three cycles
    lsb_full = 1'b1;
    drive_inst(mk(6'd20, 5'd9, 5'd1, 5'd0, 32'h300, 1'b1));
    inst_valid_from_iq = 1'b1;
    @(negedge clk);
    inst_valid_from_iq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_held_ready", inst_ready_to_iq, 0);
      chk("lw_held_en", {30'd0, rs_enable, lsb_enable}, 0);
      @(negedge clk);
    end
    lsb_full = 1'b0;
    #1 chk("lw_release_ready", inst_ready_to_iq, 1);
    @(negedge clk);
    chk("lw_lsb_en", lsb_enable, 1);
    chk("lw_rs_en", rs_enable, 0);
    chk("lw_pc", pc_out, 32'h300);
    @(negedge clk);
    chk("lw_pulse_end", lsb_enable, 0);

    // rdy low stretches a pending pulse and blocks capture
    drive_inst(mk(6'd10, 5'd4, 5'd0, 5'd0, 32'h400, 1'b0));
    inst_valid_from_iq = 1'b1;
    @(negedge clk);
    inst_valid_from_iq = 1'b0;
    @(negedge clk);
    chk("rdy_pulse", rs_enable, 1);
    rdy = 1'b0;
    drive_inst(mk(6'd10, 5'd4, 5'd0, 5'd0, 32'h404, 1'b0));
    inst_valid_from_iq = 1'b1;
    #1 chk("rdy_low_ready", inst_ready_to_iq, 0);
    @(negedge clk);
    chk("rdy_low_stretch", {30'd0, rs_enable, rob_enable}, 3);
    inst_valid_from_iq = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy_resume_clear", rs_enable, 0);
    chk("rdy_no_capture", inst_ready_to_iq, 1);
    @(negedge clk);
    chk("rdy_no_issue", rs_enable, 0);

    // Misbranch with a held instruction and a pulse pending
    drive_inst(mk(6'd10, 5'd2, 5'd0, 5'd0, 32'h500, 1'b0));
    inst_valid_from_iq = 1'b1;
    @(negedge clk);
    drive_inst(mk(6'd10, 5'd2, 5'd0, 5'd0, 32'h504, 1'b0));
    @(negedge clk);
    chk("mis_pulse", rs_enable, 1);
    inst_valid_from_iq = 1'b0;
    misbranch_flag = 1'b1;
    #1 chk("mis_ready", inst_ready_to_iq, 0);
    @(negedge clk);
    misbranch_flag = 1'b0;
    chk("mis_clear", {28'd0, rs_enable, lsb_enable, rob_enable, rename_enable_to_reg}, 0);
    #1 chk("mis_slot_empty", inst_ready_to_iq, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis_never_issued", {29'd0, rs_enable, lsb_enable, rob_enable}, 0);
    end

    // Randomized stream against an in-order scoreboard
    prev_en = 1'b0; expect_issue = 1'b0; st_blocked = 1'b0;
    st_o1 = '0; st_o2 = '0; st_fid = '0;
    for (int k = 0; k < 460; k++) begin
      @(negedge clk);
      drain  = (k >= 440);
      cur_en = rs_enable | lsb_enable;
      chk("rnd_alternate", {31'd0, prev_en & cur_en}, 0);
      if (expect_issue) chk("rnd_issue_due", cur_en, 1);
      if (cur_en) begin
        chk("rnd_has_inst", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          exp_i = acc_q.pop_front();
          chk("rnd_target", lsb_enable, exp_i.is_ls);
          chk("rnd_pc", pc_out, exp_i.pc);
          chk("rnd_imm", imm_out, exp_i.imm);
          chk("rnd_op", openum_out, exp_i.op);
          chk("rnd_v1", V1_out, st_o1[31:0]);
          chk("rnd_q1", Q1_out, st_o1[35:32]);
          chk("rnd_v2", V2_out, st_o2[31:0]);
          chk("rnd_q2", Q2_out, st_o2[35:32]);
          chk("rnd_rob_id", rob_id_out, st_fid);
          chk("rnd_not_blocked", st_blocked, 0);
          chk("rnd_rename", rename_enable_to_reg, exp_i.rd != 5'd0);
        end
      end
      prev_en = cur_en;

      e.q1 = 4'($urandom_range(0, 3)); e.q2 = 4'($urandom_range(0, 3));
      e.v1 = $urandom; e.v2 = $urandom;
      e.av = 1'($urandom_range(0, 1)); e.aid = 4'($urandom_range(1, 3)); e.ares = $urandom;
      e.lv = 1'($urandom_range(0, 1)); e.lid = 4'($urandom_range(1, 3)); e.lres = $urandom;
      e.r1 = 1'($urandom_range(0, 1)); e.rv1 = $urandom;
      e.r2 = 1'($urandom_range(0, 1)); e.rv2 = $urandom;
      e.fid = 4'($urandom_range(1, 15));
      apply_env(e);
      rs_full  = !drain && ($urandom_range(0, 3) == 0);
      lsb_full = !drain && ($urandom_range(0, 3) == 0);
      rob_full = !drain && ($urandom_range(0, 9) == 0);
      cur.op  = 6'($urandom_range(1, 63));
      cur.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cur.rs1 = 5'($urandom_range(0, 7)); cur.rs2 = 5'($urandom_range(0, 7));
      cur.imm = $urandom; cur.pc = 32'h1000 + 4 * k; cur.is_ls = 1'($urandom_range(0, 1));
      drive_inst(cur);
      inst_valid_from_iq = !drain && ($urandom_range(0, 9) < 6);
      #1;
      if (acc_q.size() == 0) chk("rnd_ready_empty", inst_ready_to_iq, 1);
      expect_issue = (acc_q.size() == 1) && inst_ready_to_iq;
      if (acc_q.size() != 0) begin
        st_o1 = ref_op(acc_q[0].rs1, e.q1, e.v1, e.r1, e.rv1, e);
        st_o2 = ref_op(acc_q[0].rs2, e.q2, e.v2, e.r2, e.rv2, e);
        st_fid = e.fid;
        st_blocked = rob_full | (acc_q[0].is_ls ? lsb_full : rs_full);
      end
      if (inst_ready_to_iq && inst_valid_from_iq) acc_q.push_back(cur);
    end
    chk("rnd_drained", acc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Stage directly upstream of the reservation station (RS) and load/store buffer (LSB).
- Buffers one decoded instruction from the instruction queue and resolves its source operands from the register file, the ROB and both CDBs.
- Allocates a ROB entry, renames rd, and issues the instruction as a registered one-cycle pulse to the RS (arithmetic/branch) or the LSB (load/store).

Parameters:
ROB_ID_W, 4, ROB tag width; tag 0 (ZERO_ROB) means "no dependency".
OPENUM_W, 6, operation enum width; 0 = OPENUM_NOP.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all state
inst_valid_from_iq  in  1  decoded instruction available
openum_from_iq / rd_from_iq / rs1_from_iq / rs2_from_iq  in  OPENUM_W/5/5/5  decoded fields
imm_from_iq / pc_from_iq  in  32/32  immediate, pc
is_ls_from_iq  in  1  1 = route to LSB
inst_ready_to_iq  out  1  slot can accept this cycle (combinational)
rs1_to_reg / rs2_to_reg  out  5/5  register-file read indices (combinational from slot)
Q1_from_reg / Q2_from_reg  in  ROB_ID_W  rename tags
V1_from_reg / V2_from_reg  in  32  register values
rename_enable_to_reg / rename_rd_to_reg / rename_rob_id_to_reg  out  1/5/ROB_ID_W  rename write (registered)
rob_full / rob_free_id  in  1/ROB_ID_W  ROB status, next tag
Q1_to_rob / Q2_to_rob  out  ROB_ID_W  ROB value query (combinational)
rob_ready1 / rob_value1 / rob_ready2 / rob_value2  in  1/32/1/32  query answers
rob_enable / openum_to_rob / rd_to_rob / pc_to_rob  out  1/OPENUM_W/5/32  ROB allocate (registered)
rs_full / lsb_full  in  1  target full
rs_enable / lsb_enable  out  1  issue pulses (registered)
openum_out / V1_out / V2_out / Q1_out / Q2_out / pc_out / imm_out / rob_id_out  out  OPENUM_W/32/32/ROB_ID_W/ROB_ID_W/32/32/ROB_ID_W  shared issue bus to RS and LSB
valid_arith_cdb / rob_id_arith_cdb / result_arith_cdb  in  1/ROB_ID_W/32  arithmetic CDB
valid_ls_cdb / rob_id_ls_cdb / result_ls_cdb  in  1/ROB_ID_W/32  load/store CDB
misbranch_flag  in  1  synchronous flush

Behaviour:
- State: one instruction slot; slot_valid is the state bit (EMPTY/HELD).
- Reset (rst=0, async):
  - slot_valid=0.
  - All enables 0.
  - openum_out/openum_to_rob = NOP.
  - All data, tag and index outputs 0.
- misbranch_flag=1 at a clock edge (regardless of rdy):
  - Clears slot_valid and all enables.
  - Nothing is captured that cycle.
- rdy=0:
  - No state change; inst_ready_to_iq=0.
  - Enables hold their value, so a pulse can stretch under rdy=0. Consumers already gate on rdy.
- issue_fire = rdy & !misbranch_flag & slot_valid & !rob_full & !rob_enable & target_ok.
  - target_ok = is_ls ? (!lsb_full & !lsb_enable) : (!rs_full & !rs_enable).
  - Result: at most one issue every other cycle. This is the decided conservative rule, because downstream full flags lag our registered enable by one cycle.
- inst_ready_to_iq = rdy & !misbranch_flag & (!slot_valid | issue_fire).
  - Capture into the slot occurs when inst_ready_to_iq & inst_valid_from_iq.
- Operand resolution is evaluated in the issue cycle. Per operand, in priority order:
  - rs==0 -> Q=0, V=0.
  - Else reg Q==0 -> V from reg.
  - Else arith CDB valid and tag match -> arith result, Q=0.
  - Else LS CDB valid and tag match -> LS result, Q=0.
  - Else rob_ready -> rob_value, Q=0.
  - Else Q = reg tag, V=0.
- On issue_fire, the next edge registers:
  - rob_id_out=rob_free_id; the issue bus; rob_enable=1.
  - rs_enable or lsb_enable=1.
  - rename_enable_to_reg=1 only when rd!=0.
- Without issue_fire, the next edge clears enables to 0; bus values are don't-care but hold.
- Simultaneous issue and capture in the same cycle is legal: the slot reloads.
- Latency: instruction captured at edge N reaches the RS/LSB enable at edge N+1 at the earliest.

Decomposition:
- Shared constant package/include:
  - DATA_TYPE, ADDR_TYPE, ROB_ID_TYPE, OPENUM_TYPE.
  - ZERO_ROB, ZERO_WORD, OPENUM_NOP, TRUE/FALSE.
- One natural sub-module, operand_resolver: the combinational per-operand priority mux, instantiated twice.

Test Plan:
1. Reset then ADDI (rs1=x2 with Q=0, V=5), rob_free_id=3 -> one cycle after capture: rs_enable=1, V1_out=5, Q1_out=0, rob_id_out=3, rename rd with tag 3.
2. rs1 reg Q=7, and arith CDB broadcasts tag 7 with 0x1234 in the issue cycle -> Q1_out=0, V1_out=0x1234. Repeat with rob_ready1=1, value 0x55 and no CDB -> V1_out=0x55.
3. Back-to-back valid instructions -> enables asserted on alternate cycles only; inst_ready_to_iq low in the cycles where the slot is held.
4. LW with lsb_full=1 for 3 cycles -> slot held, no enable; lsb_full drops -> lsb_enable pulse next edge, rs_enable stays 0.
5. misbranch_flag while slot held and a pulse is pending -> all enables 0 next edge, slot empty, the held instruction is never issued.
6. Instruction with rd=0 and rs1=0 -> rename_enable_to_reg stays 0; V1_out=0, Q1_out=0 even if the reg file reports Q1=5.
